// File: rtl/video_timing_gen_if.sv
// Video timing bundle: run control in, sync/enable/position/frame status out.
// The generator drives through the master modport; a sink or bench uses slave.
interface video_timing_gen_if;
    logic        enable;
    logic        hs;
    logic        vs;
    logic        de;
    logic [10:0] x;
    logic [10:0] y;
    logic        frame_start;
    logic [7:0]  frame_cnt;

    modport master (
        input  enable,
        output hs,
        output vs,
        output de,
        output x,
        output y,
        output frame_start,
        output frame_cnt
    );

    modport slave (
        output enable,
        input  hs,
        input  vs,
        input  de,
        input  x,
        input  y,
        input  frame_start,
        input  frame_cnt
    );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: divides clk50 down to a pixel strobe and scans h/v counters.
// All outputs are registered decodes of the counters, so they lag the counters by one clk50.
module video_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input logic                clk50,
    input logic                rst,
    video_timing_gen_if.master vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0]  CE_LAST   = 4'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEGIN  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEGIN  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        SYNC_ON   = (SYNC_POL != 0);

    // ST_ARM waits for the first pixel strobe after idle; that strobe enters pixel (0,0).
    localparam logic [0:0] ST_ARM = 1'b0;
    localparam logic [0:0] ST_RUN = 1'b1;

    logic [3:0]  ce_cnt;
    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic [0:0]  state;
    logic        wrap_q;

    logic        pix_ce;
    logic        h_last;
    logic        v_last;
    logic        active;
    logic        h_sync;
    logic        v_sync;
    logic        hs_d;
    logic        vs_d;
    logic [10:0] x_d;
    logic [10:0] y_d;

    always_comb begin
        pix_ce = (ce_cnt == CE_LAST);
        h_last = (h_cnt == H_LAST);
        v_last = (v_cnt == V_LAST);
        active = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        h_sync = (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
        v_sync = (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);
        hs_d   = h_sync ? SYNC_ON : ~SYNC_ON;
        vs_d   = v_sync ? SYNC_ON : ~SYNC_ON;
        x_d    = active ? h_cnt : 11'd0;
        y_d    = active ? v_cnt : 11'd0;
    end

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            ce_cnt          <= 4'd0;
            h_cnt           <= 11'd0;
            v_cnt           <= 11'd0;
            state           <= ST_ARM;
            wrap_q          <= 1'b0;
            vid.hs          <= ~SYNC_ON;
            vid.vs          <= ~SYNC_ON;
            vid.de          <= 1'b0;
            vid.x           <= 11'd0;
            vid.y           <= 11'd0;
            vid.frame_start <= 1'b0;
            vid.frame_cnt   <= 8'd0;
        end else if (!vid.enable) begin
            // Idle: park everything at the origin but keep the frame count.
            ce_cnt          <= 4'd0;
            h_cnt           <= 11'd0;
            v_cnt           <= 11'd0;
            state           <= ST_ARM;
            wrap_q          <= 1'b0;
            vid.hs          <= ~SYNC_ON;
            vid.vs          <= ~SYNC_ON;
            vid.de          <= 1'b0;
            vid.x           <= 11'd0;
            vid.y           <= 11'd0;
            vid.frame_start <= 1'b0;
        end else begin
            ce_cnt <= pix_ce ? 4'd0 : ce_cnt + 4'd1;

            if (pix_ce) begin
                if (state == ST_ARM) begin
                    state <= ST_RUN;
                end else begin
                    h_cnt <= h_last ? 11'd0 : h_cnt + 11'd1;
                    if (h_last) begin
                        v_cnt <= v_last ? 11'd0 : v_cnt + 11'd1;
                    end
                end
            end

            // wrap_q marks the counters landing on (0,0); delaying it one clk50 lines it up with the outputs.
            wrap_q          <= pix_ce && (state == ST_RUN) && h_last && v_last;
            vid.frame_start <= wrap_q;
            if (wrap_q) begin
                vid.frame_cnt <= vid.frame_cnt + 8'd1;
            end

            if (state == ST_RUN) begin
                vid.hs <= hs_d;
                vid.vs <= vs_d;
                vid.de <= active;
                vid.x  <= x_d;
                vid.y  <= y_d;
            end else begin
                vid.hs <= ~SYNC_ON;
                vid.vs <= ~SYNC_ON;
                vid.de <= 1'b0;
                vid.x  <= 11'd0;
                vid.y  <= 11'd0;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: small rasters so whole frames fit in a short run.
// dut_a: CLK_DIV=2, 16x8 raster, active-low sync; dut_b: CLK_DIV=1, 4x3 raster, active-high sync.
module tb_video_timing_gen;

    logic clk50 = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;

    always #5 clk50 = ~clk50;

    video_timing_gen_if bus_a ();
    video_timing_gen_if bus_b ();

    video_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(0)
    ) dut_a (
        .clk50(clk50),
        .rst  (rst_a),
        .vid  (bus_a)
    );

    video_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(2), .H_FP(1), .H_SYNC(1), .H_BP(0),
        .V_ACTIVE(1), .V_FP(1), .V_SYNC(1), .V_BP(0), .SYNC_POL(1)
    ) dut_b (
        .clk50(clk50),
        .rst  (rst_b),
        .vid  (bus_b)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_hs"}, 32'(bus_a.hs), 32'd1);
        check({tag, "_vs"}, 32'(bus_a.vs), 32'd1);
        check({tag, "_de"}, 32'(bus_a.de), 32'd0);
        check({tag, "_x"}, 32'(bus_a.x), 32'd0);
        check({tag, "_y"}, 32'(bus_a.y), 32'd0);
        check({tag, "_fs"}, 32'(bus_a.frame_start), 32'd0);
    endtask

    initial begin
        int de_line;
        int hs_line;
        int de_frame;
        int hs_frame;
        int vs_frame;
        int fs_cnt;
        int vs_rise_cnt;
        int vs_fall_cnt;
        int vs_rise_t0;
        int vs_rise_t1;
        int vs_fall_t0;
        logic prev_vs;

        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.enable = 1'b1;
        bus_b.enable = 1'b1;
        #1;
        check_idle_a("rst_async");
        check("rst_async_fcnt", 32'(bus_a.frame_cnt), 32'd0);

        for (int i = 0; i < 5; i++) begin
            @(negedge clk50);
            check_idle_a("rst_hold");
            check("rst_hold_fcnt", 32'(bus_a.frame_cnt), 32'd0);
        end
        check("b_rst_hs", 32'(bus_b.hs), 32'd0);
        check("b_rst_vs", 32'(bus_b.vs), 32'd0);

        // Release reset: arm edge, pixel-strobe edge, then pixel (0,0) on the third edge.
        rst_a = 1'b0;
        @(negedge clk50);
        check("start_e1_de", 32'(bus_a.de), 32'd0);
        @(negedge clk50);
        check("start_e2_de", 32'(bus_a.de), 32'd0);
        @(negedge clk50);

        de_line = 0; hs_line = 0; de_frame = 0; hs_frame = 0; vs_frame = 0;
        fs_cnt = 0; vs_rise_cnt = 0; vs_fall_cnt = 0;
        vs_rise_t0 = -1; vs_rise_t1 = -1; vs_fall_t0 = -1;
        prev_vs = bus_a.vs;

        for (int t = 0; t <= 586; t++) begin
            if (t > 0) @(negedge clk50);
            if (t < 32) begin
                de_line += int'(bus_a.de);
                hs_line += int'(!bus_a.hs);
            end
            if (t < 256) begin
                de_frame += int'(bus_a.de);
                hs_frame += int'(!bus_a.hs);
                vs_frame += int'(!bus_a.vs);
            end
            fs_cnt += int'(bus_a.frame_start);
            if (!prev_vs && bus_a.vs) begin
                if (vs_rise_cnt == 0) vs_rise_t0 = t;
                if (vs_rise_cnt == 1) vs_rise_t1 = t;
                vs_rise_cnt++;
            end
            if (prev_vs && !bus_a.vs) begin
                if (vs_fall_cnt == 0) vs_fall_t0 = t;
                vs_fall_cnt++;
            end
            prev_vs = bus_a.vs;

            if (t == 0) begin
                check("first_de", 32'(bus_a.de), 32'd1);
                check("first_x", 32'(bus_a.x), 32'd0);
                check("first_y", 32'(bus_a.y), 32'd0);
                check("first_hs", 32'(bus_a.hs), 32'd1);
                check("first_fs", 32'(bus_a.frame_start), 32'd0);
            end
            if (t == 5) check("x_at_t5", 32'(bus_a.x), 32'd2);
            if (t == 15) check("x_last_act", 32'(bus_a.x), 32'd7);
            if (t == 16) begin
                check("de_fall", 32'(bus_a.de), 32'd0);
                check("x_blank", 32'(bus_a.x), 32'd0);
            end
            if (t == 19) check("hs_before", 32'(bus_a.hs), 32'd1);
            if (t == 20) check("hs_assert", 32'(bus_a.hs), 32'd0);
            if (t == 25) check("hs_last", 32'(bus_a.hs), 32'd0);
            if (t == 26) check("hs_release", 32'(bus_a.hs), 32'd1);
            if (t == 32) begin
                check("line1_de", 32'(bus_a.de), 32'd1);
                check("line1_x", 32'(bus_a.x), 32'd0);
                check("line1_y", 32'(bus_a.y), 32'd1);
            end
            if (t == 70) begin
                check("mid_x", 32'(bus_a.x), 32'd3);
                check("mid_y", 32'(bus_a.y), 32'd2);
            end
            if (t == 128) begin
                check("vblank_de", 32'(bus_a.de), 32'd0);
                check("vblank_y", 32'(bus_a.y), 32'd0);
            end
            if (t == 256) begin
                check("wrap_fs", 32'(bus_a.frame_start), 32'd1);
                check("wrap_fcnt", 32'(bus_a.frame_cnt), 32'd1);
                check("wrap_de", 32'(bus_a.de), 32'd1);
                check("wrap_x", 32'(bus_a.x), 32'd0);
                check("wrap_y", 32'(bus_a.y), 32'd0);
            end
            if (t == 257) check("fs_one_cycle", 32'(bus_a.frame_start), 32'd0);
            if (t == 586) begin
                check("pre_drop_x", 32'(bus_a.x), 32'd5);
                check("pre_drop_y", 32'(bus_a.y), 32'd2);
                check("pre_drop_fcnt", 32'(bus_a.frame_cnt), 32'd2);
            end
        end

        check("line_de_clocks", 32'(de_line), 32'd16);
        check("line_hs_clocks", 32'(hs_line), 32'd6);
        check("frame_de_clocks", 32'(de_frame), 32'd64);
        check("frame_hs_clocks", 32'(hs_frame), 32'd48);
        check("frame_vs_clocks", 32'(vs_frame), 32'd64);
        check("vs_fall_t0", 32'(vs_fall_t0), 32'd160);
        check("vs_rise_t0", 32'(vs_rise_t0), 32'd224);
        check("vs_rise_period", 32'(vs_rise_t1 - vs_rise_t0), 32'd256);
        check("vs_rise_count", 32'(vs_rise_cnt), 32'd2);
        check("vs_fall_count", 32'(vs_fall_cnt), 32'd2);
        check("fs_count", 32'(fs_cnt), 32'd2);

        // Drop enable mid-line: idle on the very next edge, frame count held.
        bus_a.enable = 1'b0;
        @(negedge clk50);
        check_idle_a("disable");
        check("disable_fcnt", 32'(bus_a.frame_cnt), 32'd2);
        for (int i = 0; i < 4; i++) @(negedge clk50);
        check("disable_hold_de", 32'(bus_a.de), 32'd0);
        check("disable_hold_fcnt", 32'(bus_a.frame_cnt), 32'd2);

        bus_a.enable = 1'b1;
        @(negedge clk50);
        check("reen_e1_de", 32'(bus_a.de), 32'd0);
        @(negedge clk50);
        check("reen_e2_de", 32'(bus_a.de), 32'd0);
        @(negedge clk50);
        check("reen_de", 32'(bus_a.de), 32'd1);
        check("reen_x", 32'(bus_a.x), 32'd0);
        check("reen_y", 32'(bus_a.y), 32'd0);
        check("reen_fs", 32'(bus_a.frame_start), 32'd0);
        check("reen_fcnt", 32'(bus_a.frame_cnt), 32'd2);

        // Reset pulse mid-line, asserted between clock edges.
        for (int i = 0; i < 10; i++) @(negedge clk50);
        check("prerst_x", 32'(bus_a.x), 32'd5);
        check("prerst_de", 32'(bus_a.de), 32'd1);
        #2;
        rst_a = 1'b1;
        #1;
        check_idle_a("midrst");
        check("midrst_fcnt", 32'(bus_a.frame_cnt), 32'd0);
        @(negedge clk50);
        rst_a = 1'b0;
        @(negedge clk50);
        @(negedge clk50);
        check("rerun_e2_de", 32'(bus_a.de), 32'd0);
        @(negedge clk50);
        check("rerun_de", 32'(bus_a.de), 32'd1);
        check("rerun_x", 32'(bus_a.x), 32'd0);
        check("rerun_y", 32'(bus_a.y), 32'd0);
        check("rerun_fcnt", 32'(bus_a.frame_cnt), 32'd0);

        // dut_b: 12-clock frames, run 256 of them and watch frame_cnt wrap.
        rst_b = 1'b0;
        @(negedge clk50);
        check("b_e1_de", 32'(bus_b.de), 32'd0);
        @(negedge clk50);
        fs_cnt = 0;
        for (int t = 0; t <= 3072; t++) begin
            if (t > 0) @(negedge clk50);
            fs_cnt += int'(bus_b.frame_start);
            if (t == 0) begin
                check("b_first_de", 32'(bus_b.de), 32'd1);
                check("b_first_hs", 32'(bus_b.hs), 32'd0);
                check("b_first_fs", 32'(bus_b.frame_start), 32'd0);
            end
            if (t == 2) check("b_h2_de", 32'(bus_b.de), 32'd0);
            if (t == 3) check("b_hs_active_high", 32'(bus_b.hs), 32'd1);
            if (t == 4) check("b_line1_de", 32'(bus_b.de), 32'd0);
            if (t == 7) check("b_vs_before", 32'(bus_b.vs), 32'd0);
            if (t == 8) check("b_vs_active_high", 32'(bus_b.vs), 32'd1);
            if (t == 12) begin
                check("b_fs1", 32'(bus_b.frame_start), 32'd1);
                check("b_fcnt1", 32'(bus_b.frame_cnt), 32'd1);
                check("b_wrap_x", 32'(bus_b.x), 32'd0);
            end
            if (t == 3071) check("b_fcnt_255", 32'(bus_b.frame_cnt), 32'd255);
            if (t == 3072) begin
                check("b_fcnt_wrap", 32'(bus_b.frame_cnt), 32'd0);
                check("b_fs_last", 32'(bus_b.frame_start), 32'd1);
            end
        end
        check("b_fs_count", 32'(fs_cnt), 32'd256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- CLK_DIV, 2: clk50 cycles per pixel, range 1..16.
- H_ACTIVE, 640: active pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: active lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- SYNC_POL, 0: sync asserted level; 0 = active-low.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk50, in, 1: the single clock, 50 MHz.
- rst, in, 1: asynchronous, active-high reset.
- enable, in, 1: run the timing; low forces idle.
- hs, out, 1: horizontal sync.
- vs, out, 1: vertical sync.
- de, out, 1: active-video data enable.
- x, out, 11: active pixel column; 0 outside active video.
- y, out, 11: active line row; 0 outside active video.
- frame_start, out, 1: one-clk50 pulse at each frame start.
- frame_cnt, out, 8: count of frames generated, wrapping.

Function
REQ-003 H_TOTAL SHALL be H_ACTIVE+H_FP+H_SYNC+H_BP, and V_TOTAL SHALL be V_ACTIVE+V_FP+V_SYNC+V_BP; both SHALL be at most 2047.
REQ-004 Prescaler ce_cnt SHALL count 0..CLK_DIV-1 while enable=1. pix_ce SHALL be 1 when ce_cnt==CLK_DIV-1. With CLK_DIV=1, pix_ce SHALL be 1 every cycle.
REQ-005 h_cnt SHALL advance on pix_ce and wrap from H_TOTAL-1 to 0. v_cnt SHALL advance only on that wrap, and SHALL wrap from V_TOTAL-1 to 0.
REQ-006 Decode SHALL be as follows:
- active = (h_cnt<H_ACTIVE) and (v_cnt<V_ACTIVE).
- hsync region = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- vsync region = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), applied for whole lines (v_cnt-aligned).
REQ-007 hs, vs, de, x and y SHALL be registered, reflecting the counter values one clk50 after they change (fixed latency 1).
REQ-008 hs SHALL equal SYNC_POL in the hsync region and ~SYNC_POL elsewhere; vs SHALL follow the same rule on the vsync region.
REQ-009 de SHALL equal active. x/y SHALL equal h_cnt/v_cnt when active, and 0 otherwise.
REQ-010 frame_start SHALL pulse high for exactly one clk50 cycle when the counters transition to (0,0), aligned with the output registers. It SHALL not pulse on entry from idle.
REQ-011 frame_cnt SHALL increment on each frame_start and wrap from 255 to 0 with no flag.
REQ-012 enable=0 SHALL clear ce_cnt, h_cnt and v_cnt synchronously. Outputs SHALL go idle on the next clk50 edge: hs=vs=~SYNC_POL, de=0, x=y=0, frame_start=0.
REQ-013 frame_cnt SHALL hold its value while enable=0.
REQ-014 On enable 0->1, output SHALL restart from (0,0), with the first pix_ce CLK_DIV cycles later.
REQ-015 Exactly one vs assertion edge and one vs deassertion edge SHALL occur per frame. This lets a vsync-edge frame-rate counter on clk50 read the frame rate directly.
REQ-016 Nominal frame period SHALL be CLK_DIV*H_TOTAL*V_TOTAL clk50 cycles: 840000 at defaults, about 59.52 frames per second.

Reset
REQ-017 While rst=1, asynchronously:
- ce_cnt=h_cnt=v_cnt=0 and frame_cnt=0.
- hs=vs=~SYNC_POL, de=0, x=y=0, frame_start=0.
REQ-018 After rst is released, operation SHALL begin on the first clk50 edge with enable=1, exactly as in REQ-014.
REQ-019 rst asserted mid-frame SHALL abort the frame with no partial frame_start pulse.

Verification
REQ-020 Reset, defaults: hold rst for 5 clocks with enable=1 -> hs=1, vs=1, de=0, x=0, y=0, frame_cnt=0 throughout.
REQ-021 Line timing, defaults: de high for 1280 clocks per line; hs low for 192 clocks, starting 32 clocks after de falls; line period 1600 clocks.
REQ-022 Frame timing: vs low for 3200 clocks per frame; vs rising edges spaced 840000 clocks apart; over 50,000,000 clocks, 59 or 60 vs rising edges.
REQ-023 frame_cnt: run 256 frames with CLK_DIV=1 and a small raster -> frame_start counted 256 times and frame_cnt returns to 0.
REQ-024 enable dropped at h_cnt=300, v_cnt=100 -> next edge all outputs idle; re-enable -> first de rises CLK_DIV+1 clocks later with x=0, y=0.
REQ-025 rst pulse mid-line -> outputs idle immediately with no clock; after release, restart from (0,0) with frame_cnt=0.
